// File: rtl/fractcam_ctrl_pkg.sv
// Shared types and helpers for the fractcam search/write sequencer.
// State encoding, index-width derivation and counter widths live here.
package fractcam_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SEARCH_WAIT = 2'd1,
        ST_RESULT      = 2'd2,
        ST_WRITE_WAIT  = 2'd3
    } state_t;

    // Search latency is bounded to 1..15, so a 4-bit down-counter suffices.
    localparam int LAT_CNT_WIDTH = 4;

    localparam int STAT_WIDTH = 32;

    function automatic int idx_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fractcam_prio_enc.sv
// Registered lowest-index priority encoder over the TCAM match vector.
// Captures hit/index only when en is high; holds otherwise.
module fractcam_prio_enc
    import fractcam_ctrl_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int IDX_WIDTH = idx_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DEPTH-1:0]     match,
    output logic                 hit,
    output logic [IDX_WIDTH-1:0] index
);

    logic [IDX_WIDTH-1:0] index_next;

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_next = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                index_next = IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit   <= 1'b0;
            index <= '0;
        end else if (en) begin
            hit   <= |match;
            index <= index_next;
        end
    end

endmodule

// File: rtl/fractcam_ctrl.sv
// Search/write arbiter and sequencer in front of the fractcam TCAM datapath.
// Optional hit/miss/write counters are enabled with `define FRACTCAM_CTRL_STATS_EN.
//
// state          | meaning
// ST_IDLE        | arbitrate; s_ready / w_ready may be granted
// ST_SEARCH_WAIT | key held on TCAM, latency counter running
// ST_RESULT      | m_valid high, waiting for m_ready
// ST_WRITE_WAIT  | strobe issued, waiting for TCAM wr_busy to drop
module fractcam_ctrl
    import fractcam_ctrl_pkg::*;
#(
    parameter int TCAM_DEPTH        = 1024,
    parameter int TCAM_WIDTH        = 160,
    parameter int SLICEM_ADDR_WIDTH = 7,
    parameter int SEARCH_LATENCY    = 2,
    parameter int WR_STARVE_MAX     = 8,
    parameter int IDX_WIDTH         = idx_width(TCAM_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [TCAM_WIDTH-1:0]        s_key,
    input  logic                         s_valid,
    output logic                         s_ready,

    input  logic [TCAM_WIDTH*8-1:0]      w_data,
    input  logic [TCAM_WIDTH*8-1:0]      w_keep,
    input  logic [SLICEM_ADDR_WIDTH-1:0] w_sel,
    input  logic                         w_valid,
    output logic                         w_ready,

    output logic                         m_hit,
    output logic [IDX_WIDTH-1:0]         m_index,
    output logic                         m_valid,
    input  logic                         m_ready,

`ifdef FRACTCAM_CTRL_STATS_EN
    output logic [STAT_WIDTH-1:0]        stat_hits,
    output logic [STAT_WIDTH-1:0]        stat_misses,
    output logic [STAT_WIDTH-1:0]        stat_writes,
`endif

    output logic [TCAM_WIDTH-1:0]        tcam_search_key,
    output logic [TCAM_WIDTH*8-1:0]      tcam_wr_data,
    output logic [TCAM_WIDTH*8-1:0]      tcam_wr_keep,
    output logic [SLICEM_ADDR_WIDTH-1:0] tcam_wr_sel,
    output logic                         tcam_wr_enable,
    input  logic                         tcam_wr_busy,
    input  logic [TCAM_DEPTH-1:0]        tcam_match
);

    localparam int STARVE_W = $clog2(WR_STARVE_MAX + 1);

    state_t                   state;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt;
    logic [STARVE_W-1:0]      starve;

    logic in_idle;
    logic starve_max;
    logic grant_w;
    logic grant_s;
    logic capture;
    logic result_done;

    assign in_idle    = (state == ST_IDLE) && !rst;
    assign starve_max = (starve == STARVE_W'(WR_STARVE_MAX));

    // Writes yield to searches until the starve limit, and never while the TCAM is busy.
    assign grant_w = in_idle && w_valid && (!s_valid || starve_max) && !tcam_wr_busy;
    assign grant_s = in_idle && s_valid && !grant_w;

    assign w_ready = grant_w;
    assign s_ready = grant_s;

    assign capture     = (state == ST_SEARCH_WAIT) && (lat_cnt == LAT_CNT_WIDTH'(1));
    assign result_done = (state == ST_RESULT) && m_valid && m_ready;

    fractcam_prio_enc #(
        .DEPTH     (TCAM_DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_prio_enc (
        .clk   (clk),
        .rst   (rst),
        .en    (capture),
        .match (tcam_match),
        .hit   (m_hit),
        .index (m_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            lat_cnt         <= '0;
            starve          <= '0;
            m_valid         <= 1'b0;
            tcam_search_key <= '0;
            tcam_wr_data    <= '0;
            tcam_wr_keep    <= '0;
            tcam_wr_sel     <= '0;
            tcam_wr_enable  <= 1'b0;
        end else begin
            tcam_wr_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_w) begin
                        tcam_wr_data   <= w_data;
                        tcam_wr_keep   <= w_keep;
                        tcam_wr_sel    <= w_sel;
                        tcam_wr_enable <= 1'b1;
                        starve         <= '0;
                        state          <= ST_WRITE_WAIT;
                    end else if (grant_s) begin
                        tcam_search_key <= s_key;
                        lat_cnt         <= LAT_CNT_WIDTH'(SEARCH_LATENCY);
                        if (!w_valid) begin
                            starve <= '0;
                        end else if (!starve_max) begin
                            starve <= starve + 1'b1;
                        end
                        state <= ST_SEARCH_WAIT;
                    end
                end
                ST_SEARCH_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (capture) begin
                        m_valid <= 1'b1;
                        state   <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (result_done) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_WRITE_WAIT: begin
                    // The strobe cycle itself always counts as the minimum wait.
                    if (!tcam_wr_enable && !tcam_wr_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRACTCAM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_writes <= '0;
        end else begin
            if (result_done) begin
                if (m_hit) begin
                    stat_hits <= stat_hits + 1'b1;
                end else begin
                    stat_misses <= stat_misses + 1'b1;
                end
            end
            if (grant_w) begin
                stat_writes <= stat_writes + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fractcam_ctrl.sv
// Directed self-checking bench for fractcam_ctrl: latency, priority encoding,
// write/busy sequencing, write starvation limit, result backpressure and reset.
module tb_fractcam_ctrl;

    localparam int DEPTH = 1024;
    localparam int W     = 160;
    localparam int SAW   = 7;
    localparam int IDXW  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      s_key;
    logic              s_valid;
    logic              s_ready;
    logic [W*8-1:0]    w_data;
    logic [W*8-1:0]    w_keep;
    logic [SAW-1:0]    w_sel;
    logic              w_valid;
    logic              w_ready;
    logic              m_hit;
    logic [IDXW-1:0]   m_index;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      tcam_search_key;
    logic [W*8-1:0]    tcam_wr_data;
    logic [W*8-1:0]    tcam_wr_keep;
    logic [SAW-1:0]    tcam_wr_sel;
    logic              tcam_wr_enable;
    logic              tcam_wr_busy;
    logic [DEPTH-1:0]  tcam_match;
`ifdef FRACTCAM_CTRL_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
    logic [31:0]       stat_writes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fractcam_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .s_key           (s_key),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .w_data          (w_data),
        .w_keep          (w_keep),
        .w_sel           (w_sel),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .m_hit           (m_hit),
        .m_index         (m_index),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
`ifdef FRACTCAM_CTRL_STATS_EN
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writes     (stat_writes),
`endif
        .tcam_search_key (tcam_search_key),
        .tcam_wr_data    (tcam_wr_data),
        .tcam_wr_keep    (tcam_wr_keep),
        .tcam_wr_sel     (tcam_wr_sel),
        .tcam_wr_enable  (tcam_wr_enable),
        .tcam_wr_busy    (tcam_wr_busy),
        .tcam_match      (tcam_match)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_key = '0; s_valid = 1'b0;
        w_data = '0; w_keep = '0; w_sel = '0; w_valid = 1'b0;
        m_ready = 1'b0; tcam_wr_busy = 1'b0; tcam_match = '0;
        step(); step();
        s_valid = 1'b1; w_valid = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: s_ready=%0b w_ready=%0b expected 0 0", s_ready, w_ready);
        end
        s_valid = 1'b0; w_valid = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || m_hit !== 1'b0 || m_index !== '0 || tcam_wr_enable !== 1'b0
            || tcam_search_key !== '0 || tcam_wr_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_valid=%0b m_hit=%0b m_index=%0d wr_en=%0b expected all 0",
                     m_valid, m_hit, m_index, tcam_wr_enable);
        end
`ifdef FRACTCAM_CTRL_STATS_EN
        n_checks++;
        if (stat_hits !== 0 || stat_misses !== 0 || stat_writes !== 0) begin
            n_fail++;
            $display("FAIL reset_stats: hits=%0d misses=%0d writes=%0d expected 0", stat_hits, stat_misses, stat_writes);
        end
`endif
        step();
        rst = 1'b0;
        step();
    endtask

    // Issue one search with the given match vector and check latency and result.
    task automatic do_search(input logic [W-1:0] key, input logic [DEPTH-1:0] match,
                             input logic exp_hit, input int exp_idx, input string name);
        int cnt;
        s_key = key; s_valid = 1'b1; m_ready = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_grant: s_ready=%0b expected 1", name, s_ready);
        end
        tcam_match = match;
        step();
        s_valid = 1'b0;
        cnt = 1;
        while (m_valid !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected 3", name, cnt);
        end
        n_checks++;
        if (m_hit !== exp_hit || m_index !== IDXW'(exp_idx) || tcam_search_key !== key) begin
            n_fail++;
            $display("FAIL %s_result: hit=%0b index=%0d key=%0h expected hit=%0b index=%0d key=%0h",
                     name, m_hit, m_index, tcam_search_key, exp_hit, exp_idx, key);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        tcam_match = '0;
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_retire: m_valid=%0b expected 0", name, m_valid);
        end
    endtask

    task automatic test_search();
        logic [DEPTH-1:0] m;
        m = '0; m[37] = 1'b1;
        do_search(W'(16'hABCD), m, 1'b1, 37, "single");
        m = '0; m[5] = 1'b1; m[900] = 1'b1; m[1023] = 1'b1;
        do_search(W'(32'h1234_5678), m, 1'b1, 5, "multi");
        m = '0;
        do_search(W'(8'h55), m, 1'b0, 0, "miss");
        m = '1;
        do_search({W{1'b1}}, m, 1'b1, 0, "all_ones");
        m = '0; m[1023] = 1'b1;
        do_search(W'(1), m, 1'b1, 1023, "top_bit");
    endtask

    task automatic test_write_busy();
        logic [W*8-1:0] d;
        logic [W*8-1:0] k;
        d = {40{32'hA5A5_0F0F}};
        k = {40{32'h00FF_FF00}};
        // A pending write is held off while the TCAM reports busy.
        w_data = d; w_keep = k; w_sel = 7'd3; w_valid = 1'b1; tcam_wr_busy = 1'b1;
        #1;
        n_checks++;
        if (w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_busy_block: w_ready=%0b expected 0", w_ready);
        end
        step();
        tcam_wr_busy = 1'b0;
        #1;
        n_checks++;
        if (w_ready !== 1'b1 || tcam_wr_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_grant: w_ready=%0b wr_en=%0b expected 1 0", w_ready, tcam_wr_enable);
        end
        step();
        w_valid = 1'b0; w_data = '0; w_keep = '0; w_sel = '0;
        s_key = W'(9); s_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tcam_wr_busy = 1'b1;
            #1;
            n_checks++;
            if (s_ready !== 1'b0 || tcam_wr_enable !== (c == 1)) begin
                n_fail++;
                $display("FAIL wr_wait_c%0d: s_ready=%0b wr_en=%0b expected 0 %0b", c, s_ready, tcam_wr_enable, c == 1);
            end
            if (c == 1) begin
                n_checks++;
                if (tcam_wr_sel !== 7'd3 || tcam_wr_data !== d || tcam_wr_keep !== k) begin
                    n_fail++;
                    $display("FAIL wr_payload: sel=%0d expected 3 (data/keep compared too)", tcam_wr_sel);
                end
            end
            step();
        end
        tcam_wr_busy = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_release_cycle: s_ready=%0b expected 0", s_ready);
        end
        step();
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_back_idle: s_ready=%0b expected 1", s_ready);
        end
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic [18:0] got_w;
        int          n;
        int          cyc;
        tcam_match = '0; m_ready = 1'b1; tcam_wr_busy = 1'b0;
        s_valid = 1'b1; w_valid = 1'b1; s_key = W'(77); w_sel = 7'd11;
        got_w = '0;
        n = 0;
        cyc = 0;
        while (n < 19 && cyc < 300) begin
            #1;
            if (s_ready === 1'b1 || w_ready === 1'b1) begin
                got_w[n] = w_ready;
                n++;
            end
            step();
            cyc++;
        end
        s_valid = 1'b0; w_valid = 1'b0;
        n_checks++;
        if (n != 19) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants expected 19", n);
        end
        for (int i = 0; i < 19; i++) begin
            n_checks++;
            if (got_w[i] !== (i == 8 || i == 17)) begin
                n_fail++;
                $display("FAIL starve_order_%0d: write=%0b expected %0b", i, got_w[i], i == 8 || i == 17);
            end
        end
        for (int i = 0; i < 6; i++) step();
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cnt;
        tcam_match = '0; tcam_match[100] = 1'b1;
        s_key = W'(16'hBEEF); s_valid = 1'b1; m_ready = 1'b0;
        step();
        s_key = W'(16'hCAFE);
        cnt = 0;
        while (m_valid !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        tcam_match = '0; tcam_match[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (m_valid !== 1'b1 || m_hit !== 1'b1 || m_index !== IDXW'(100) || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%0b hit=%0b index=%0d s_ready=%0b expected 1 1 100 0",
                         c, m_valid, m_hit, m_index, s_ready);
            end
            step();
        end
        m_ready = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshake_ready: s_ready=%0b expected 0", s_ready);
        end
        step();
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after: m_valid=%0b s_ready=%0b expected 0 1", m_valid, s_ready);
        end
        s_valid = 1'b0;
        tcam_match = '0;
        step();
    endtask

    task automatic test_reset_mid();
        logic seen;
        // Reset while in SEARCH_WAIT.
        tcam_match = '1;
        s_key = W'(16'h1111); s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || tcam_search_key !== '0 || m_hit !== 1'b0 || m_index !== '0) begin
            n_fail++;
            $display("FAIL rst_search: m_valid=%0b key=%0h hit=%0b expected 0 0 0", m_valid, tcam_search_key, m_hit);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (m_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_search_spurious: m_valid seen=%0b expected 0", seen);
        end
        tcam_match = '0;
        // Reset while in WRITE_WAIT with the TCAM busy.
        w_data = '1; w_keep = '1; w_sel = 7'd5; w_valid = 1'b1;
        step();
        w_valid = 1'b0;
        tcam_wr_busy = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tcam_wr_busy = 1'b0;
        n_checks++;
        if (tcam_wr_enable !== 1'b0 || tcam_wr_sel !== '0 || tcam_wr_data !== '0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_write: wr_en=%0b sel=%0d m_valid=%0b expected 0 0 0", tcam_wr_enable, tcam_wr_sel, m_valid);
        end
`ifdef FRACTCAM_CTRL_STATS_EN
        n_checks++;
        if (stat_hits !== 0 || stat_misses !== 0 || stat_writes !== 0) begin
            n_fail++;
            $display("FAIL rst_stats: hits=%0d misses=%0d writes=%0d expected 0", stat_hits, stat_misses, stat_writes);
        end
`endif
        s_valid = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_write_idle: s_ready=%0b expected 1", s_ready);
        end
        s_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_search();
        test_write_busy();
        test_starvation();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fractcam_ctrl.md
Name: fractcam_ctrl

Overview:
- Sequencer and arbiter in front of the fractcam_top datapath.
- Two requester streams share the single TCAM: search requests (valid/ready) and rule-write requests (valid/ready).
- Writes are serialized against searches and gated by wr_busy.
- After a fixed search latency, the match vector is captured and priority-encoded into a hit flag plus entry index. The result is returned on a valid/ready result stream.

Parameters:
- TCAM_DEPTH, 1024, number of TCAM entries (match vector width).
- TCAM_WIDTH, 160, key width in bits.
- SLICEM_ADDR_WIDTH, 7, width of the write row select; equals clog2(TCAM_DEPTH/8), minimum 1.
- SEARCH_LATENCY, 2, cycles from key driven to match valid at the TCAM; legal range 1..15.
- WR_STARVE_MAX, 8, consecutive search grants allowed while a write is pending.
- IDX_WIDTH, clog2(TCAM_DEPTH), width of the result index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_key  in  TCAM_WIDTH  search key.
- s_valid  in  1  search request valid.
- s_ready  out  1  search request accepted.
- w_data  in  TCAM_WIDTH*8  rule data for one SLICEM row.
- w_keep  in  TCAM_WIDTH*8  rule care mask.
- w_sel  in  SLICEM_ADDR_WIDTH  target row.
- w_valid  in  1  write request valid.
- w_ready  out  1  write request accepted.
- m_hit  out  1  any entry matched.
- m_index  out  IDX_WIDTH  lowest matching entry index; 0 on miss.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- tcam_search_key  out  TCAM_WIDTH  to TCAM search_key.
- tcam_wr_data  out  TCAM_WIDTH*8  to TCAM wr_tcam_data.
- tcam_wr_keep  out  TCAM_WIDTH*8  to TCAM wr_tcam_keep.
- tcam_wr_sel  out  SLICEM_ADDR_WIDTH  to TCAM wr_enable_sel.
- tcam_wr_enable  out  1  one-cycle write strobe.
- tcam_wr_busy  in  1  from TCAM wr_busy.
- tcam_match  in  TCAM_DEPTH  from TCAM match.

Behaviour:
- Reset values:
  - All outputs 0 and all registers cleared.
  - s_ready = 0 and w_ready = 0.
  - State IDLE, starve counter 0.
- Reset mid-operation: any in-flight search or write is abandoned; no result is emitted.

State machine:
- IDLE
  - Arbitration: if w_valid && (!s_valid || starve == WR_STARVE_MAX) && !tcam_wr_busy, grant the write. Otherwise, if s_valid, grant the search. Otherwise stay in IDLE.
  - Ready timing: s_ready and w_ready are combinational grant outputs in IDLE only; at most one is high per cycle.
  - Search grant: register s_key into tcam_search_key, load the latency counter with SEARCH_LATENCY, and go to SEARCH_WAIT. starve increments (saturating at WR_STARVE_MAX) if w_valid was high; otherwise it clears.
  - Write grant: register w_data, w_keep and w_sel; assert tcam_wr_enable for exactly the next cycle; clear starve; go to WRITE_WAIT.
- SEARCH_WAIT
  - tcam_search_key is held stable while the counter decrements.
  - When the counter reaches 1, the next edge captures tcam_match into the priority encoder register and the state goes to RESULT.
  - Grant to m_valid latency = SEARCH_LATENCY+1 cycles.
- RESULT
  - m_valid = 1, with m_hit and m_index held stable until m_ready.
  - On m_valid && m_ready, go to IDLE.
  - There is no back-to-back overlap: each search is fully retired before the next grant.
- WRITE_WAIT
  - Entered the cycle after the strobe.
  - Wait at least one cycle, then remain while tcam_wr_busy = 1.
  - Return to IDLE on the first cycle tcam_wr_busy = 0.
  - No search is issued while in this state.

Priority encoding:
- The lowest set bit of tcam_match wins.
- m_hit = |match.
- All-zero match gives m_hit = 0 and m_index = 0.
- All-ones match gives m_index = 0.

Simultaneous events:
- Search and write valid in the same cycle: the search wins until starve == WR_STARVE_MAX, then the write wins.
- A write pending while tcam_wr_busy = 1 in IDLE is not granted.

Optional Feature:
- Macro: FRACTCAM_CTRL_STATS_EN.
- When defined, three 32-bit outputs are added: stat_hits, stat_misses, stat_writes.
  - stat_hits and stat_misses increment on each result handshake, according to m_hit.
  - stat_writes increments on each write grant.
  - All three wrap at 2^32 and clear on rst.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package fractcam_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_SEARCH_WAIT, ST_RESULT, ST_WRITE_WAIT;
  - the IDX_WIDTH derivation function;
  - the stats counter width constant.
- Sub-module fractcam_prio_enc: registered lowest-index priority encoder, TCAM_DEPTH in, hit and index out, one-cycle latency, with enable input.

Test Plan:
- Single search: s_key = 0xABCD, match bit 37 set after 2 cycles -> m_valid 3 cycles after the grant, m_hit = 1, m_index = 37.
- Multi-hit and miss: match bits 5, 900 and 1023 set -> m_index = 5; match = 0 -> m_hit = 0, m_index = 0.
- Write with busy: w_sel = 3 granted, tcam_wr_enable high exactly 1 cycle, busy held for 10 cycles -> no s_ready during busy; IDLE on the first busy = 0 cycle.
- Starvation: s_valid and w_valid both held high -> 8 search grants, then 1 write grant, then searches resume with the counter cleared.
- Result backpressure: m_ready low for 5 cycles -> m_valid, m_hit and m_index stable throughout; s_ready stays 0 until the handshake.
- Reset in SEARCH_WAIT and in WRITE_WAIT -> outputs 0 the next cycle, no spurious m_valid; the stats counters (with FRACTCAM_CTRL_STATS_EN) read 0.
